// File: rtl/video_window_scaler_pkg.sv
// Shared constants and window geometry type for the integer-scaled GBA window
// placed inside the HDMI raster.
package video_window_scaler_pkg;

  localparam int SRC_W_GBA     = 240;
  localparam int SRC_H_GBA     = 160;
  localparam int FRAME_W_720P  = 1280;
  localparam int FRAME_H_720P  = 720;
  localparam int FRAME_W_1080P = 1920;
  localparam int FRAME_H_1080P = 1080;
  localparam int GEOM_W        = 13;

  typedef struct packed {
    logic [GEOM_W-1:0] x_start;
    logic [GEOM_W-1:0] x_stop;
    logic [GEOM_W-1:0] y_start;
    logic [GEOM_W-1:0] y_stop;
  } geom_t;

  // Window centred in the frame; an odd margin truncates toward left/top.
  function automatic geom_t calc_geom(input int s, input int src_w, input int src_h,
                                      input int frame_w, input int frame_h);
    geom_t g;
    g.x_start = GEOM_W'((frame_w - s * src_w) / 2);
    g.x_stop  = GEOM_W'((frame_w - s * src_w) / 2 + s * src_w);
    g.y_start = GEOM_W'((frame_h - s * src_h) / 2);
    g.y_stop  = GEOM_W'((frame_h - s * src_h) / 2 + s * src_h);
    return g;
  endfunction

endpackage

// File: rtl/window_geometry.sv
// Registered scale-to-window geometry plus the acceptance check applied to a
// requested scale factor.
module window_geometry
  import video_window_scaler_pkg::*;
#(
  parameter int SRC_W     = SRC_W_GBA,
  parameter int SRC_H     = SRC_H_GBA,
  parameter int FRAME_W   = FRAME_W_720P,
  parameter int FRAME_H   = FRAME_H_720P,
  parameter int MAX_SCALE = 6,
  parameter int DEF_SCALE = 4,
  parameter int READ_LEAD = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  scale,
  input  logic [2:0]  req,
  output logic [12:0] x_start,
  output logic [12:0] x_stop,
  output logic [12:0] y_start,
  output logic [12:0] y_stop,
  output logic        req_ok
);

  geom_t geom_p1;

  // A scale must fit the frame and leave room for the read address lead.
  function automatic logic scale_fits(input int r);
    int w_span;
    int h_span;
    w_span = r * SRC_W;
    h_span = r * SRC_H;
    return (r >= 1) && (r <= MAX_SCALE) && (w_span <= FRAME_W) && (h_span <= FRAME_H)
           && (((FRAME_W - w_span) / 2) >= READ_LEAD);
  endfunction

  // Stage p1: geometry follows the active scale one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      geom_p1 <= calc_geom(DEF_SCALE, SRC_W, SRC_H, FRAME_W, FRAME_H);
    end else begin
      geom_p1 <= calc_geom(int'(scale), SRC_W, SRC_H, FRAME_W, FRAME_H);
    end
  end

  assign req_ok  = scale_fits(int'(req));
  assign x_start = geom_p1.x_start;
  assign x_stop  = geom_p1.x_stop;
  assign y_start = geom_p1.y_start;
  assign y_stop  = geom_p1.y_stop;

endmodule

// File: rtl/video_window_scaler.sv
// Timing and line-cache addressing core for integer-scaled GBA video in the
// HDMI raster, with frame-boundary scale changes and HDMI resync control.
module video_window_scaler
  import video_window_scaler_pkg::*;
#(
  parameter int SRC_W        = SRC_W_GBA,
  parameter int SRC_H        = SRC_H_GBA,
  parameter int FRAME_W      = FRAME_W_720P,
  parameter int FRAME_H      = FRAME_H_720P,
  parameter int MAX_SCALE    = 6,
  parameter int DEF_SCALE    = 4,
  parameter int READ_LEAD    = 3,
  parameter int SMOOTH_PHASE = 1
) (
  input  logic        pxlClk,
  input  logic        rst,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  input  logic [2:0]  scaleSel,
  input  logic        sameLine,
  input  logic        newFrameIn,
  output logic        drawActive,
  output logic        cacheUpdate,
  output logic        nextLine,
  output logic [7:0]  curPxl,
  output logic [2:0]  gridXCnt,
  output logic [2:0]  lineCnt,
  output logic [2:0]  smoothXCnt,
  output logic        gridAct,
  output logic [2:0]  activeScale,
  output logic        scaleErr,
  output logic        enableOut,
  output logic        resyncEvt,
  output logic [7:0]  resyncCnt
);

  logic [12:0] x_start, x_stop, y_start, y_stop;
  logic        req_ok;

  logic        draw_p1, cache_p1, next_p1, grid_act_p1;
  logic        err_p1, en_p1, evt_p1, nf_p1;
  logic [7:0]  cur_p1, resync_cnt_p1;
  logic [2:0]  pxl_cnt_p1, grid_x_p1, smooth_x_p1, line_p1, scale_p1;

  logic [12:0] cx_w, cy_w, rd_lo, rd_hi;
  logic [2:0]  s_max, pxl_cnt_nxt, grid_x_nxt, smooth_x_nxt, line_nxt;
  logic [7:0]  cur_nxt;
  logic        line_end, frame_end, rd_clear, nf_rise, forced;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  window_geometry #(
    .SRC_W     (SRC_W),
    .SRC_H     (SRC_H),
    .FRAME_W   (FRAME_W),
    .FRAME_H   (FRAME_H),
    .MAX_SCALE (MAX_SCALE),
    .DEF_SCALE (DEF_SCALE),
    .READ_LEAD (READ_LEAD)
  ) u_geom (
    .clk     (pxlClk),
    .rst     (rst),
    .scale   (scale_p1),
    .req     (scaleSel),
    .x_start (x_start),
    .x_stop  (x_stop),
    .y_start (y_start),
    .y_stop  (y_stop),
    .req_ok  (req_ok)
  );

  assign cx_w      = {1'b0, cx};
  assign cy_w      = {2'b00, cy};
  assign s_max     = scale_p1 - 3'd1;
  assign line_end  = (cx == 12'(FRAME_W - 1));
  assign frame_end = line_end && (cy == 11'(FRAME_H - 1));

  // The read window is shifted left by the lead so cache data lands on time.
  assign rd_lo    = x_start - 13'(READ_LEAD);
  assign rd_hi    = x_stop - 13'(READ_LEAD);
  assign rd_clear = (cx_w <= rd_lo) || (cx_w > rd_hi);

  // A new frame arriving on the expected rows is in phase; anywhere else forces a resync.
  assign nf_rise = newFrameIn && !nf_p1;
  assign forced  = nf_rise && (cy_w != (y_start - 13'd1)) && (cy_w != y_start);

  always_comb begin
    pxl_cnt_nxt = pxl_cnt_p1 + 3'd1;
    cur_nxt     = cur_p1;
    if (rd_clear) begin
      pxl_cnt_nxt = '0;
      cur_nxt     = '0;
    end else if (pxl_cnt_p1 == s_max) begin
      pxl_cnt_nxt = '0;
      cur_nxt     = cur_p1 + 8'd1;
    end
  end

  always_comb begin
    grid_x_nxt   = grid_x_p1 + 3'd1;
    smooth_x_nxt = smooth_x_p1 + 3'd1;
    if ((cx_w == x_start) || (grid_x_p1 == s_max)) begin
      grid_x_nxt   = '0;
      smooth_x_nxt = 3'(SMOOTH_PHASE);
    end
  end

  always_comb begin
    line_nxt = line_p1;
    if (line_end) begin
      if (cy == 11'(FRAME_H - 1)) begin
        line_nxt = '0;
      end else if (line_p1 == s_max) begin
        line_nxt = '0;
      end else if (cy_w >= y_start) begin
        line_nxt = line_p1 + 3'd1;
      end
    end
  end

  // Stage p1: every raster-derived output registered one cycle after cx/cy
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      draw_p1       <= 1'b0;
      cache_p1      <= 1'b0;
      next_p1       <= 1'b0;
      pxl_cnt_p1    <= '0;
      cur_p1        <= '0;
      grid_x_p1     <= '0;
      smooth_x_p1   <= '0;
      line_p1       <= '0;
      grid_act_p1   <= 1'b0;
      scale_p1      <= 3'(DEF_SCALE);
      err_p1        <= 1'b0;
      en_p1         <= 1'b0;
      evt_p1        <= 1'b0;
      nf_p1         <= 1'b0;
      resync_cnt_p1 <= '0;
    end else begin
      draw_p1     <= (cx_w >= x_start) && (cx_w < x_stop) && (cy_w >= y_start) && (cy_w < y_stop);
      cache_p1    <= (cx_w == x_stop);
      next_p1     <= (cx_w == x_stop) && !sameLine && (cy_w >= y_start) && (line_p1 == s_max);
      pxl_cnt_p1  <= pxl_cnt_nxt;
      cur_p1      <= cur_nxt;
      grid_x_p1   <= grid_x_nxt;
      smooth_x_p1 <= smooth_x_nxt;
      line_p1     <= line_nxt;
      grid_act_p1 <= (grid_x_nxt == 3'd0) || (line_nxt == 3'd0);
      nf_p1       <= newFrameIn;
      evt_p1      <= forced;
      if (forced) begin
        en_p1         <= 1'b0;
        resync_cnt_p1 <= sat_inc8(resync_cnt_p1);
      end else if (newFrameIn) begin
        en_p1 <= 1'b1;
      end
      err_p1 <= frame_end && !req_ok;
      if (frame_end && req_ok) begin
        scale_p1 <= scaleSel;
      end
    end
  end

  assign drawActive  = draw_p1;
  assign cacheUpdate = cache_p1;
  assign nextLine    = next_p1;
  assign curPxl      = cur_p1;
  assign gridXCnt    = grid_x_p1;
  assign lineCnt     = line_p1;
  assign smoothXCnt  = smooth_x_p1;
  assign gridAct     = grid_act_p1;
  assign activeScale = scale_p1;
  assign scaleErr    = err_p1;
  assign enableOut   = en_p1;
  assign resyncEvt   = evt_p1;
  assign resyncCnt   = resync_cnt_p1;

endmodule

// File: doc/video_window_scaler.md
Name: video_window_scaler

Overview:
Parametrised timing and addressing core for integer-scaled GBA video inside the HDMI raster. It takes the raster position (cx, cy) and produces:
- the active-window flag
- line-cache read address, cacheUpdate and nextLine strobes
- grid and smoothing phase counters
- HDMI enable/resync control

It generalises the fixed-scale window logic: source size, frame size and read lead are parameters, and scale is runtime-selectable at frame boundaries with validity checking.

Parameters:
SRC_W, 240, source pixels per line
SRC_H, 160, source lines
FRAME_W, 1280, active raster width
FRAME_H, 720, active raster height
MAX_SCALE, 6, largest accepted scale factor
DEF_SCALE, 4, scale after reset
READ_LEAD, 3, cycles the cache read address leads the displayed pixel
SMOOTH_PHASE, 1, value loaded into smoothXCnt at each source-pixel start

Ports:
pxlClk in 1 pixel clock
rst in 1 reset
cx in 12 raster column
cy in 11 raster row
scaleSel in 3 requested scale factor (1..MAX_SCALE)
sameLine in 1 source line not yet advanced; suppresses nextLine
newFrameIn in 1 source frame-start level
drawActive out 1 current pixel lies inside the scaled window
cacheUpdate out 1 one-cycle pulse at window right edge
nextLine out 1 one-cycle request to advance the source line
curPxl out 8 line-cache read address
gridXCnt out 3 horizontal phase within a source pixel
lineCnt out 3 vertical phase within a source line
smoothXCnt out 3 smoothing horizontal phase
gridAct out 1 grid line active
activeScale out 3 scale in force for the current frame
scaleErr out 1 one-cycle pulse when a request is rejected
enableOut out 1 HDMI enable
resyncEvt out 1 one-cycle pulse on forced resync
resyncCnt out 8 saturating resync counter

Behaviour:
- Clocking and reset:
  - Single clock pxlClk; rst is synchronous, active-high.
  - Reset values: all outputs 0 except activeScale = DEF_SCALE.
  - Geometry registers hold the values derived from DEF_SCALE.
  - Reset mid-frame takes effect at the next edge regardless of state.
- Geometry (registered):
  - S = activeScale.
  - xStart = (FRAME_W − S·SRC_W)/2, truncating; xStop = xStart + S·SRC_W.
  - yStart = (FRAME_H − S·SRC_H)/2, truncating; yStop = yStart + S·SRC_H.
  - Widths are 13-bit unsigned. Products use a constant multiply; no DSP is needed.
- Scale latch:
  - Sampled only on the cycle cx == FRAME_W−1 && cy == FRAME_H−1.
  - Valid when: 1 ≤ scaleSel ≤ MAX_SCALE, scaleSel·SRC_W ≤ FRAME_W, scaleSel·SRC_H ≤ FRAME_H, and resulting xStart ≥ READ_LEAD.
  - Valid: activeScale takes scaleSel; geometry updates on the following cycle.
  - Invalid: activeScale holds and scaleErr pulses.
  - Changes to scaleSel mid-frame have no effect.
- All raster-derived outputs are registered, with 1 cycle latency from cx/cy:
  - drawActive: xStart ≤ cx < xStop && yStart ≤ cy < yStop.
  - cacheUpdate: cx == xStop.
  - nextLine: cx == xStop && !sameLine && cy ≥ yStart && lineCnt == S−1.
- Read address:
  - If cx ≤ xStart−READ_LEAD or cx > xStop−READ_LEAD, pxlCntScale and curPxl clear.
  - Otherwise pxlCntScale increments. On reaching S−1 it wraps to 0 and curPxl increments.
- gridXCnt and smoothXCnt:
  - If cx == xStart or gridXCnt == S−1: gridXCnt ← 0 and smoothXCnt ← SMOOTH_PHASE.
  - Otherwise both increment; 3-bit wrap is permitted.
- lineCnt: updates only at cx == FRAME_W−1, in priority order:
  - cy == FRAME_H−1 → 0;
  - else lineCnt == S−1 → 0;
  - else cy ≥ yStart → +1.
- gridAct = (gridXCnt == 0) || (lineCnt == 0), decoded from registered state.
- Enable/resync:
  - newFrameIn high sets enableOut.
  - A rising edge of newFrameIn (tracked by a delay register) with cy ∉ {yStart−1, yStart} clears enableOut, pulses resyncEvt, and increments resyncCnt (saturating at 255).
  - Clear wins over set in the same cycle. If newFrameIn stays high, enableOut returns to 1 on the next cycle.

Decomposition:
- Shared package: SRC_W/SRC_H defaults, frame constants per video mode, and a geometry struct type {xStart, xStop, yStart, yStop}.
- One sub-module, window_geometry: registered S → geometry computation plus the validity check, instantiated once.

Test Plan:
- Reset, defaults (1280×720, S=4): xStart=160, yStart=40. On row cy=40, drawActive is high for cx 160..1119, delayed 1 cycle. cacheUpdate pulses once, after cx=1120.
- Same row, read address: counting starts at cx=158. curPxl steps every 4 cycles, first 0→1 at cx=161. It reaches 240 after cx=1117 and clears at cx=1118.
- Rows cy=40..47, sameLine=0: nextLine pulses only on cy=43 and cy=47, and lineCnt cycles 0,1,2,3. Repeat with sameLine=1: no pulses.
- scaleSel=3 set mid-frame: no change until the frame wraps. Next frame has xStart=280, yStart=120. Then scaleSel=6 (1440 > 1280): scaleErr pulses and activeScale stays 3.
- Resync:
  - newFrameIn rising at cy=39: no resyncEvt, enableOut=1.
  - Rising at cy=300: enableOut=0 for 1 cycle, resyncEvt=1, resyncCnt 0→1.
  - 256 forced resyncs: resyncCnt holds 255.
- Assert rst while drawActive=1 with S=3: next cycle all outputs are 0 and activeScale=4.
